// File: rtl/list_walker.sv
// rtl/list_walker.sv - linked-list traversal engine emitting node payload beats
module list_walker #(
    parameter int              MEM_SIZE  = 512,
    parameter int              WORD      = 24,
    parameter int              AW        = $clog2(MEM_SIZE),
    parameter int              MAX_NODES = 128,
    parameter logic [WORD-1:0] NULL_PTR  = 24'hFFFFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dir,
    input  logic [AW-1:0]   head,
    output logic [AW-1:0]   A1,
    output logic [AW-1:0]   A2,
    input  logic [WORD-1:0] D1,
    input  logic [WORD-1:0] D2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_x,
    output logic [WORD-1:0] out_y,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      node_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_DATA, S_FETCH_LINK, S_EMIT, S_DONE, S_ERROR
    } state_t;

    // Highest base address whose four node words still fit in memory.
    localparam logic [AW-1:0] MAX_BASE = AW'(MEM_SIZE - 4);
    localparam logic [7:0]    MAX_CNT  = 8'(MAX_NODES);

    state_t          r_state;
    logic [AW-1:0]   r_cur;
    logic [WORD-1:0] r_link;
    logic            r_dir;
    logic [AW-1:0]   r_a1;
    logic [AW-1:0]   r_a2;
    logic            r_out_valid;
    logic [WORD-1:0] r_out_x;
    logic [WORD-1:0] r_out_y;
    logic            r_out_last;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_node_count;

    logic [WORD-1:0] w_link_sel;
    logic            w_link_ok;
    logic            w_head_ok;
    logic            w_hs;
    logic [7:0]      w_cnt_inc;
    logic [AW-1:0]   w_next_base;

    // Link fetched this cycle and its legality; the upper bits must be clear
    // so a wide garbage value cannot alias onto a legal address.
    always_comb begin
        w_link_sel  = r_dir ? D2 : D1;
        w_link_ok   = (w_link_sel[WORD-1:AW] == '0) && (w_link_sel[AW-1:0] <= MAX_BASE);
        w_head_ok   = (head <= MAX_BASE);
        w_hs        = r_out_valid && out_ready;
        w_cnt_inc   = r_node_count + 8'd1;
        w_next_base = r_link[AW-1:0];
    end

    // Traversal FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur        <= '0;
            r_link       <= '0;
            r_dir        <= 1'b0;
            r_a1         <= '0;
            r_a2         <= '0;
            r_out_valid  <= 1'b0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_node_count <= '0;
        end else if (r_state != S_IDLE && abort) begin
            // Abort wins over a same-cycle handshake: the beat is dropped.
            r_state     <= S_IDLE;
            r_a1        <= '0;
            r_a2        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_a1   <= '0;
                    r_a2   <= '0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_cur        <= head;
                        r_dir        <= dir;
                        r_node_count <= '0;
                        r_busy       <= 1'b1;
                        if (w_head_ok) begin
                            r_err   <= 1'b0;
                            r_a1    <= head + AW'(2);
                            r_a2    <= head + AW'(3);
                            r_state <= S_FETCH_DATA;
                        end else begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_FETCH_DATA: begin
                    r_out_x <= D1;
                    r_out_y <= D2;
                    r_a1    <= r_cur;
                    r_a2    <= r_cur + AW'(1);
                    r_state <= S_FETCH_LINK;
                end
                S_FETCH_LINK: begin
                    r_link <= w_link_sel;
                    r_a1   <= '0;
                    r_a2   <= '0;
                    if (w_link_sel == NULL_PTR) begin
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else if (w_link_ok) begin
                        r_out_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_ERROR;
                    end
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_out_valid  <= 1'b0;
                        r_node_count <= w_cnt_inc;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_cnt_inc == MAX_CNT) begin
                            // Too many nodes: treat as a cyclic or runaway list.
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_cur   <= w_next_base;
                            r_a1    <= w_next_base + AW'(2);
                            r_a2    <= w_next_base + AW'(3);
                            r_state <= S_FETCH_DATA;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign A1         = r_a1;
    assign A2         = r_a2;
    assign out_valid  = r_out_valid;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign node_count = r_node_count;

endmodule

// File: tb/tb_list_walker.sv
// tb/tb_list_walker.sv - randomized self-checking bench for list_walker
module tb_list_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        dir;
    logic [8:0]  head;
    logic [8:0]  A1;
    logic [8:0]  A2;
    logic [23:0] D1;
    logic [23:0] D2;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_x;
    logic [23:0] out_y;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  node_count;

    int checks = 0;
    int failures = 0;

    logic [23:0] mem [512];
    assign D1 = mem[A1];
    assign D2 = mem[A2];

    always #5 clk = ~clk;

    list_walker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir(dir),
        .head(head), .A1(A1), .A2(A2), .D1(D1), .D2(D2),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_y(out_y), .out_last(out_last), .busy(busy), .done(done),
        .err(err), .node_count(node_count)
    );

    // Observed beats and events from the last walk
    logic [23:0] q_x[$];
    logic [23:0] q_y[$];
    bit          q_last[$];
    int          c_done_cnt, c_done_cyc, c_first_valid, c_stall_bad;
    bit          c_err_c1, c_timeout;

    // Reference model results
    logic [23:0] m_x[$];
    logic [23:0] m_y[$];
    bit          m_last[$];
    bit          m_err;

    task automatic fill_random_mem();
        for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);
    endtask

    // Walks the list in memory by the node-layout rules and lists the beats.
    task automatic model(input logic [8:0] h, input bit d);
        int cur;
        int cnt;
        bit fin;
        logic [23:0] lk;
        m_x.delete(); m_y.delete(); m_last.delete();
        m_err = 0;
        cur = int'(h);
        cnt = 0;
        fin = 0;
        if (cur > 508) begin
            m_err = 1;
            fin = 1;
        end
        while (!fin) begin
            lk = d ? mem[cur + 1] : mem[cur];
            if (lk == 24'hFFFFFF) begin
                m_x.push_back(mem[cur + 2]); m_y.push_back(mem[cur + 3]); m_last.push_back(1);
                fin = 1;
            end else if (lk <= 24'd508) begin
                m_x.push_back(mem[cur + 2]); m_y.push_back(mem[cur + 3]); m_last.push_back(0);
                cnt++;
                if (cnt == 128) begin
                    m_err = 1;
                    fin = 1;
                end
                cur = int'(lk);
            end else begin
                m_err = 1;
                fin = 1;
            end
        end
    endtask

    // Drives one traversal and records what the DUT produced.
    task automatic walk(input logic [8:0] h, input bit d, input int ready_pct,
                        input bit stall_first, input bit noise_start, input int budget);
        int c;
        bit stalled;
        logic [23:0] hx, hy;
        logic hl;
        q_x.delete(); q_y.delete(); q_last.delete();
        c_done_cnt = 0; c_done_cyc = -1; c_first_valid = -1; c_stall_bad = 0;
        c_err_c1 = 0; c_timeout = 0; stalled = 0;
        @(negedge clk);
        start = 1; head = h; dir = d; out_ready = 0;
        @(negedge clk);
        start = 0;
        c = 1;
        while (c < budget) begin
            if (c == 1) c_err_c1 = err;
            if (!busy) break;
            if (done) begin c_done_cnt++; c_done_cyc = c; end
            if (out_valid && c_first_valid < 0) c_first_valid = c;
            if (stall_first && out_valid && !stalled) begin
                stalled = 1;
                hx = out_x; hy = out_y; hl = out_last;
                for (int k = 0; k < 5; k++) begin
                    out_ready = 0;
                    @(negedge clk);
                    c++;
                    if (!out_valid || out_x !== hx || out_y !== hy || out_last !== hl)
                        c_stall_bad++;
                end
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid && out_ready) begin
                q_x.push_back(out_x); q_y.push_back(out_y); q_last.push_back(out_last);
            end
            if (noise_start) begin
                start = ($urandom_range(0, 3) == 0);
                head  = 9'($urandom);
                dir   = 1'($urandom);
            end
            @(negedge clk);
            c++;
        end
        if (c >= budget) c_timeout = 1;
        start = 0;
        out_ready = 0;
    endtask

    task automatic build_fwd_list();
        fill_random_mem();
        mem[8]  = 24'd20;      mem[9]  = 24'hFFFFFF;
        mem[20] = 24'd4;       mem[21] = 24'd8;
        mem[4]  = 24'hFFFFFF;  mem[5]  = 24'd20;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; abort = 0; dir = 0; head = '0; out_ready = 0;
        fill_random_mem();
        repeat (3) @(negedge clk);
        checks++;
        if ({A1, A2} !== 18'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", {A1, A2}); end
        checks++;
        if ({out_valid, out_last, busy, done, err} !== 5'd0) begin
            failures++; $display("FAIL reset_flags got=%0b exp=0", {out_valid, out_last, busy, done, err});
        end
        checks++;
        if ({out_x, out_y, node_count} !== 56'd0) begin
            failures++; $display("FAIL reset_data got=%0h exp=0", {out_x, out_y, node_count});
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic compare_walk(input string name);
        checks++;
        if (c_timeout) begin failures++; $display("FAIL %s_timeout got=1 exp=0", name); end
        checks++;
        if (q_x.size() != m_x.size()) begin
            failures++; $display("FAIL %s_beats got=%0d exp=%0d", name, q_x.size(), m_x.size());
        end else begin
            for (int i = 0; i < m_x.size(); i++) begin
                checks++;
                if (q_x[i] !== m_x[i] || q_y[i] !== m_y[i] || q_last[i] !== m_last[i]) begin
                    failures++;
                    $display("FAIL %s_beat%0d got=%0h/%0h/%0b exp=%0h/%0h/%0b", name, i,
                             q_x[i], q_y[i], q_last[i], m_x[i], m_y[i], m_last[i]);
                end
            end
        end
        checks++;
        if (err !== m_err) begin failures++; $display("FAIL %s_err got=%0b exp=%0b", name, err, m_err); end
        checks++;
        if (int'(node_count) != m_x.size()) begin
            failures++; $display("FAIL %s_count got=%0d exp=%0d", name, node_count, m_x.size());
        end
        checks++;
        if (c_done_cnt != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", name, c_done_cnt); end
    endtask

    task automatic test_forward();
        build_fwd_list();
        model(9'd8, 0);
        walk(9'd8, 0, 100, 0, 0, 100);
        compare_walk("fwd");
        checks++;
        if (c_first_valid != 3) begin failures++; $display("FAIL fwd_latency got=%0d exp=3", c_first_valid); end
        checks++;
        if (c_done_cyc != 10) begin failures++; $display("FAIL fwd_done_cycle got=%0d exp=10", c_done_cyc); end
        checks++;
        if (q_x.size() == 3 && (q_x[0] !== mem[10] || q_x[1] !== mem[22] || q_x[2] !== mem[6]))
        begin failures++; $display("FAIL fwd_order got=%0h,%0h,%0h exp=%0h,%0h,%0h",
                                   q_x[0], q_x[1], q_x[2], mem[10], mem[22], mem[6]); end
    endtask

    task automatic test_reverse();
        build_fwd_list();
        model(9'd4, 1);
        walk(9'd4, 1, 100, 0, 0, 100);
        compare_walk("rev");
        checks++;
        if (q_x.size() == 3 && (q_x[0] !== mem[6] || q_x[2] !== mem[10])) begin
            failures++; $display("FAIL rev_order got=%0h,%0h exp=%0h,%0h", q_x[0], q_x[2], mem[6], mem[10]);
        end
    endtask

    task automatic test_backpressure();
        build_fwd_list();
        model(9'd8, 0);
        walk(9'd8, 0, 100, 1, 0, 100);
        compare_walk("bp");
        checks++;
        if (c_stall_bad != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", c_stall_bad); end
    endtask

    task automatic test_bad_head();
        fill_random_mem();
        model(9'd510, 0);
        walk(9'd510, 0, 100, 0, 0, 50);
        compare_walk("badhead");
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
    endtask

    task automatic test_bad_link();
        build_fwd_list();
        mem[20] = 24'h000200;
        model(9'd8, 0);
        walk(9'd8, 0, 70, 0, 0, 200);
        compare_walk("badlink");
        checks++;
        if (c_err_c1 !== 1'b0) begin failures++; $display("FAIL err_clear_on_start got=%0b exp=0", c_err_c1); end
    endtask

    task automatic test_self_loop();
        fill_random_mem();
        mem[12] = 24'd12;
        model(9'd12, 0);
        walk(9'd12, 0, 80, 0, 0, 2000);
        compare_walk("loop");
        checks++;
        if (node_count !== 8'd128) begin failures++; $display("FAIL loop_count128 got=%0d exp=128", node_count); end
    endtask

    task automatic test_random_lists();
        int slots[128];
        int n, j, tmp;
        bit d;
        logic [8:0] h;
        for (int it = 0; it < 8; it++) begin
            fill_random_mem();
            for (int i = 0; i < 128; i++) slots[i] = i * 4;
            for (int i = 127; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = slots[i]; slots[i] = slots[j]; slots[j] = tmp;
            end
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                mem[slots[i]]     = (i < n - 1) ? 24'(slots[i + 1]) : 24'hFFFFFF;
                mem[slots[i] + 1] = (i > 0) ? 24'(slots[i - 1]) : 24'hFFFFFF;
            end
            if ($urandom_range(0, 3) == 0) mem[slots[$urandom_range(0, n - 1)] + $urandom_range(0, 1)] =
                24'($urandom_range(509, 4095));
            d = 1'($urandom);
            h = d ? 9'(slots[n - 1]) : 9'(slots[0]);
            model(h, d);
            walk(h, d, 60, 0, 1, 2000);
            compare_walk("rand");
        end
    endtask

    task automatic test_abort_and_reset();
        int c;
        build_fwd_list();
        @(negedge clk);
        start = 1; head = 9'd8; dir = 0;
        @(negedge clk);
        start = 0;
        c = 0;
        while (!out_valid && c < 20) begin @(negedge clk); c++; end
        checks++;
        if (!out_valid) begin failures++; $display("FAIL abort_reach_emit got=0 exp=1"); end
        out_ready = 1; abort = 1;
        @(negedge clk);
        out_ready = 0; abort = 0;
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            failures++; $display("FAIL abort_idle got=%0b exp=000", {busy, out_valid, done});
        end
        checks++;
        if (node_count !== 8'd0) begin failures++; $display("FAIL abort_count got=%0d exp=0", node_count); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL abort_err got=%0b exp=0", err); end
        c = 0;
        repeat (3) begin @(negedge clk); if (done) c++; end
        checks++;
        if (c != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", c); end

        start = 1; head = 9'd8; dir = 0; out_ready = 1;
        @(negedge clk);
        start = 0;
        c = 0;
        repeat (4) begin @(negedge clk); if (done) c++; end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        if (done) c++;
        checks++;
        if (c != 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", c); end
        checks++;
        if ({A1, A2, out_x, out_y, node_count} !== 74'd0 ||
            {out_valid, out_last, busy, done, err} !== 5'd0) begin
            failures++; $display("FAIL reset_mid_outputs got=%0h exp=0",
                                 {A1, A2, out_x, out_y, node_count, out_valid, out_last, busy, done, err});
        end
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_backpressure();
        test_bad_head();
        test_bad_link();
        test_self_loop();
        test_random_lists();
        test_abort_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/list_walker.md
LIST_WALKER -- requirements
Module: list_walker

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, memory depth in words.
REQ-002 SHALL have parameter WORD, default 24, memory word width.
REQ-003 SHALL have parameter AW, default $clog2(MEM_SIZE), address width (9).
REQ-004 SHALL have parameter MAX_NODES, default 128, traversal length limit.
REQ-005 SHALL have parameter NULL_PTR, default 24'hFFFFFF, end-of-list link value.
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 Ports (name direction width meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin traversal; sampled only in IDLE.
- abort  in  1  terminate traversal.
- dir  in  1  0 = follow next, 1 = follow prev; latched at start.
- head  in  AW  first node base address; latched at start.
- A1  out  AW  memory read address, port 1.
- A2  out  AW  memory read address, port 2.
- D1  in  WORD  asynchronous read data, port 1.
- D2  in  WORD  asynchronous read data, port 2.
- out_valid  out  1  node beat available.
- out_ready  in  1  consumer accepts beat.
- out_x  out  WORD  node word +2.
- out_y  out  WORD  node word +3.
- out_last  out  1  beat is final node.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle end-of-traversal pulse.
- err  out  1  sticky error flag.
- node_count  out  8  accepted beats this traversal.

Function
REQ-008 Node layout SHALL be base+0 = next, base+1 = prev, base+2 = x, base+3 = y.
REQ-009 A link SHALL be valid iff bits [WORD-1:AW] are zero and its value is <= MEM_SIZE-4 (508).
REQ-010 States SHALL be IDLE, FETCH_DATA, FETCH_LINK, EMIT, DONE, ERROR.
REQ-011 IDLE: A1 = A2 = 0; start=1 latches head, dir, clears node_count and err.
REQ-012 IDLE: an invalid head SHALL go to ERROR; a valid head SHALL go to FETCH_DATA.
REQ-013 FETCH_DATA: A1 = cur+2, A2 = cur+3; SHALL register D1->out_x and D2->out_y; then FETCH_LINK.
REQ-014 FETCH_LINK: A1 = cur+0, A2 = cur+1; SHALL register link = dir ? D2 : D1.
REQ-015 FETCH_LINK: link == NULL_PTR SHALL set out_last=1 and go to EMIT.
REQ-016 FETCH_LINK: a valid link SHALL set out_last=0 and go to EMIT.
REQ-017 FETCH_LINK: any other link value SHALL go to ERROR without emitting the node.
REQ-018 EMIT: out_valid=1; out_x, out_y, out_last SHALL stay stable until out_valid&&out_ready.
REQ-019 EMIT handshake SHALL increment node_count.
REQ-020 EMIT handshake with out_last=1 SHALL go to DONE.
REQ-021 EMIT handshake with out_last=0 and node_count reaching MAX_NODES SHALL go to ERROR (cycle/overlong list).
REQ-022 EMIT handshake otherwise SHALL set cur <= link and go to FETCH_DATA.
REQ-023 Latency: start at cycle 0 -> out_valid at cycle 3; steady state 3 cycles per node with out_ready=1.
REQ-024 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-025 ERROR SHALL set err, pulse done for one cycle, then go to IDLE; err SHALL hold until the next accepted start or reset.
REQ-026 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, with no done pulse and err unchanged.
REQ-027 abort SHALL take priority over a same-cycle handshake; that beat SHALL not be counted.
REQ-028 start while busy SHALL be ignored.
REQ-029 Address arithmetic SHALL be AW-bit; cur <= 508 guarantees no wrap.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-traversal.
REQ-031 rst_n=0 SHALL clear all outputs and registers to 0: A1, A2, out_valid, out_x, out_y, out_last, busy, done, err, node_count, cur, link, dir.

Verification
REQ-032 3-node forward list at 8 -> 20 -> 4 -> NULL, dir=0, out_ready=1 -> beats for 8, 20, 4; out_last only on node 4; node_count=3; done at cycle 10.
REQ-033 Same list, head=4, dir=1 (prev links 4 -> 20 -> 8 -> NULL) -> reverse order of beats.
REQ-034 out_ready low for 5 cycles at the first beat -> out_x, out_y, out_last held stable; no extra beat; node_count increments once.
REQ-035 head=510, or next=24'h000200 -> err=1, done pulse, no beat for the bad node.
REQ-036 Self-loop node at 12 (next=12) -> exactly 128 beats, then err=1, node_count=128.
REQ-037 abort asserted in EMIT with out_ready=1, then rst_n low mid-walk -> IDLE, no done, node_count not incremented; all outputs 0 after reset.
